pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_sb.sv | 44 ++++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/halt controller: FSM states,
// register-address width and the destination-tracking scoreboard entry.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
  } sb_entry_t;

  // x0 is hard-wired zero, so a read of it never depends on a pending write.
  function automatic logic src_hit(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input sb_entry_t             e);
    return used && (rs != '0) && e.we && (e.waddr == rs);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sb.sv
// Destination scoreboard for EX/MEM/WB and RAW hazard detection for the
// instruction currently in ID.
module pipe_ctrl_sb
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  sb_entry_t             push_i,
  output logic                  hazard_o
);

  // index 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t [2:0] sb_q;
  sb_entry_t [2:0] sb_d;
  logic            hit;

  always_comb begin
    sb_d = {sb_q[1:0], push_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // WB still counts: the register file is written on the same edge ID would read it.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit = hit | src_hit(rs1_used_i, rs1_i, sb_q[i])
                | src_hit(rs2_used_i, rs2_i, sb_q[i]);
    end
    hazard_o = id_valid_i & hit;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: RAW stall insertion, wrong-path flush on redirect, and
// ebreak/invalid-instruction drain-then-halt sequencing.
//
//   state | meaning
//   RUN   | normal issue; stalls on RAW hazard, flushes IF on redirect
//   DRAIN | sys/inv accepted; waiting for it to leave WB, front end frozen
//   HALT  | simulation must finish; only reset leaves this state
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_rf_we,
  input  logic [REG_ADDR_W-1:0] id_rf_waddr,
  input  logic                  id_redirect,
  input  logic                  id_sys,
  input  logic                  id_inv,
  output logic                  if_ena,
  output logic                  if_flush,
  output logic                  ex_valid,
  output logic                  halt,
  output logic                  trap_inv,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             hazard;
  sb_entry_t        push;

  always_comb begin
    push.we    = id_rf_we & ex_valid;
    push.waddr = id_rf_waddr;
  end

  pipe_ctrl_sb u_sb (
    .clk_i      (clk),
    .rst_ni     (rst),
    .id_valid_i (id_valid),
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .rs1_used_i (id_rs1_used),
    .rs2_used_i (id_rs2_used),
    .push_i     (push),
    .hazard_o   (hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
      trap_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      trap_q  <= trap_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    trap_d   = trap_q;
    stall_d  = stall_q;
    if_ena   = 1'b0;
    if_flush = 1'b0;
    ex_valid = 1'b0;
    halt     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!id_valid) begin
          if_ena = 1'b1;
        end else if (hazard) begin
          stall_d = stall_q + CNT_W'(1);
        end else begin
          if_ena   = 1'b1;
          ex_valid = 1'b1;
          if (id_sys || id_inv) begin
            state_d = DRAIN;
            drain_d = DRN_W'(DRAIN_CYCLES - 1);
            trap_d  = id_inv & ~id_sys;
          end else if (id_redirect) begin
            if_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = HALT;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs must be quiet while reset is held, not just after the first edge.
    if (!rst) begin
      if_ena   = 1'b0;
      if_flush = 1'b0;
      ex_valid = 1'b0;
      halt     = 1'b0;
    end
  end

  assign trap_inv  = trap_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios for pipe_ctrl; expected outputs are queued as each
// cycle's stimulus is driven and checked at the following falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rf_we;
  logic [4:0]  id_rs1, id_rs2, id_rf_waddr;
  logic        id_redirect, id_sys, id_inv;
  logic        if_ena, if_flush, ex_valid, halt, trap_inv;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic        ena;
    logic        exv;
    logic        fl;
    logic        hlt;
    logic        trp;
    logic [31:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rf_we    (id_rf_we),
    .id_rf_waddr (id_rf_waddr),
    .id_redirect (id_redirect),
    .id_sys      (id_sys),
    .id_inv      (id_inv),
    .if_ena      (if_ena),
    .if_flush    (if_flush),
    .ex_valid    (ex_valid),
    .halt        (halt),
    .trap_inv    (trap_inv),
    .stall_cnt   (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("if_ena",    32'(if_ena),   32'(e.ena));
      check_eq("ex_valid",  32'(ex_valid), 32'(e.exv));
      check_eq("if_flush",  32'(if_flush), 32'(e.fl));
      check_eq("halt",      32'(halt),     32'(e.hlt));
      check_eq("trap_inv",  32'(trap_inv), 32'(e.trp));
      check_eq("stall_cnt", stall_cnt,     e.stall);
    end
  end

  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic we, input logic [4:0] wa,
                      input logic redir, input logic sys, input logic inv,
                      input logic e_ena, input logic e_exv, input logic e_fl,
                      input logic e_hlt, input logic e_trp, input logic [31:0] e_st);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = 1'b1;
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rf_we    = we;
    id_rf_waddr = wa;
    id_redirect = redir;
    id_sys      = sys;
    id_inv      = inv;
    e = '{ena: e_ena, exv: e_exv, fl: e_fl, hlt: e_hlt, trp: e_trp, stall: e_st};
    exp_q.push_back(e);
  endtask

  task automatic nop(input logic [31:0] st);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, st);
  endtask

  // Busy-looking instruction during DRAIN/HALT: must be ignored.
  task automatic hold(input logic e_hlt, input logic e_trp, input logic [31:0] st);
    step(1, 3, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, e_hlt, e_trp, st);
  endtask

  task automatic rst_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = '{ena: 1'b0, exv: 1'b0, fl: 1'b0, hlt: 1'b0, trp: 1'b0, stall: 32'd0};
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_used = 1'b1; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    id_rf_we = 1'b1; id_rf_waddr = 5'd1; id_redirect = 1'b1; id_sys = 1'b0; id_inv = 1'b0;
    rst_cycle();
    rst_cycle();

    // x0 exemption
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    nop(0);

    // back-to-back RAW on x5: three stalls
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    nop(3); nop(3); nop(3);

    // rs2 path: unused source ignored, WB match stalls
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    nop(3);
    step(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4);

    // redirect without hazard, then under a 2-cycle stall
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 4);
    nop(4);
    step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    nop(4);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 6);
    nop(6);

    // ebreak (with redirect, which must not flush)
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 6);
    hold(0, 0, 6); hold(0, 0, 6); hold(0, 0, 6);
    hold(1, 0, 6); hold(1, 0, 6); hold(1, 0, 6); hold(1, 0, 6);
    rst_cycle();

    // invalid instruction
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    hold(0, 1, 0); hold(0, 1, 0); hold(0, 1, 0);
    hold(1, 1, 0); hold(1, 1, 0);
    rst_cycle();

    // invalid together with ebreak: sys wins
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    hold(0, 0, 0); hold(0, 0, 0); hold(0, 0, 0);
    hold(1, 0, 0); hold(1, 0, 0);
    rst_cycle();

    // reset in DRAIN clears stall count and pending x12
    step(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3);
    rst_cycle();
    step(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    nop(0);

    @(posedge clk);
    @(posedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
